// File: rtl/telemetry_rx.sv
// Telemetry link receiver: 8N1 UART deserializer, AA 55 delimiter hunt, 6-byte payload reassembly.
// Optional payload nibble checking is compiled in when TELEM_RX_CHECK_EN is defined.
module telemetry_rx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic [11:0] batt_v,
  output logic [11:0] avg_curr,
  output logic [11:0] avg_torque,
  output logic        pkt_vld,
  output logic        frame_err,
  output logic        pkt_err
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bst_t;
  typedef enum logic [2:0] {HUNT1, HUNT2, P1, P2, P3, P4, P5, P6} pst_t;

  // RX is asynchronous; two flops reset to the idle level
  logic rx_meta_q, rx_s_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
    end
  end

  // ---------------- bit-level FSM ----------------
  bst_t          bst_q, bst_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bidx_q, bidx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          brdy_q, brdy_d;
  logic          ferr_q, ferr_d;
  logic          expire;

  assign expire = (cnt_q == CW'(1));

  always_comb begin
    bst_d   = bst_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    bidx_d  = bidx_q;
    shreg_d = shreg_q;
    brdy_d  = 1'b0;
    ferr_d  = 1'b0;
    case (bst_q)
      B_IDLE: begin
        if (!rx_s_q) begin
          cnt_d = HALF;
          bst_d = B_START;
        end
      end
      B_START: begin
        if (expire) begin
          if (rx_s_q) begin
            bst_d = B_IDLE;
          end else begin
            cnt_d  = FULL;
            bidx_d = 3'd0;
            bst_d  = B_DATA;
          end
        end
      end
      B_DATA: begin
        if (expire) begin
          shreg_d = {rx_s_q, shreg_q[7:1]};
          cnt_d   = FULL;
          if (bidx_q == 3'd7) bst_d = B_STOP;
          else                bidx_d = bidx_q + 3'd1;
        end
      end
      B_STOP: begin
        if (expire) begin
          if (rx_s_q) brdy_d = 1'b1;
          else        ferr_d = 1'b1;
          bst_d = B_IDLE;
        end
      end
      default: bst_d = B_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bst_q   <= B_IDLE;
      cnt_q   <= '0;
      bidx_q  <= '0;
      shreg_q <= '0;
      brdy_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      bst_q   <= bst_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      shreg_q <= shreg_d;
      brdy_q  <= brdy_d;
      ferr_q  <= ferr_d;
    end
  end

  // ---------------- packet FSM ----------------
  // shreg_q stays stable while brdy_q is high, so it doubles as the received byte
  pst_t        pst_q, pst_d;
  logic [11:0] stg_b_q, stg_b_d;
  logic [11:0] stg_c_q, stg_c_d;
  logic [3:0]  stg_tn_q, stg_tn_d;
  logic [11:0] batt_q, batt_d;
  logic [11:0] curr_q, curr_d;
  logic [11:0] torq_q, torq_d;
  logic        vld_q, vld_d;
`ifdef TELEM_RX_CHECK_EN
  logic        perr_q, perr_d;
`endif

  always_comb begin
    pst_d    = pst_q;
    stg_b_d  = stg_b_q;
    stg_c_d  = stg_c_q;
    stg_tn_d = stg_tn_q;
    batt_d   = batt_q;
    curr_d   = curr_q;
    torq_d   = torq_q;
    vld_d    = 1'b0;
`ifdef TELEM_RX_CHECK_EN
    perr_d   = 1'b0;
`endif
    if (ferr_q) begin
      pst_d = HUNT1;
    end else if (brdy_q) begin
      case (pst_q)
        HUNT1: if (shreg_q == 8'hAA) pst_d = HUNT2;
        HUNT2: begin
          if (shreg_q == 8'h55)      pst_d = P1;
          else if (shreg_q != 8'hAA) pst_d = HUNT1;
        end
        P1: begin stg_b_d[11:8] = shreg_q[3:0]; pst_d = P2; end
        P2: begin stg_b_d[7:0]  = shreg_q;      pst_d = P3; end
        P3: begin stg_c_d[11:8] = shreg_q[3:0]; pst_d = P4; end
        P4: begin stg_c_d[7:0]  = shreg_q;      pst_d = P5; end
        P5: begin stg_tn_d      = shreg_q[3:0]; pst_d = P6; end
        P6: begin
          // torque low byte bypasses staging so all three outputs move together
          batt_d = stg_b_q;
          curr_d = stg_c_q;
          torq_d = {stg_tn_q, shreg_q};
          vld_d  = 1'b1;
          pst_d  = HUNT1;
        end
        default: pst_d = HUNT1;
      endcase
`ifdef TELEM_RX_CHECK_EN
      if ((pst_q == P1 || pst_q == P3 || pst_q == P5) && shreg_q[7:4] != 4'h0) begin
        perr_d = 1'b1;
        pst_d  = HUNT1;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pst_q    <= HUNT1;
      stg_b_q  <= '0;
      stg_c_q  <= '0;
      stg_tn_q <= '0;
      batt_q   <= '0;
      curr_q   <= '0;
      torq_q   <= '0;
      vld_q    <= 1'b0;
    end else begin
      pst_q    <= pst_d;
      stg_b_q  <= stg_b_d;
      stg_c_q  <= stg_c_d;
      stg_tn_q <= stg_tn_d;
      batt_q   <= batt_d;
      curr_q   <= curr_d;
      torq_q   <= torq_d;
      vld_q    <= vld_d;
    end
  end

`ifdef TELEM_RX_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perr_q <= 1'b0;
    else     perr_q <= perr_d;
  end
  assign pkt_err = perr_q;
`else
  assign pkt_err = 1'b0;
`endif

  assign batt_v     = batt_q;
  assign avg_curr   = curr_q;
  assign avg_torque = torq_q;
  assign pkt_vld    = vld_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_telemetry_rx.sv
// Bench for telemetry_rx: byte-level packet model checked every cycle plus directed literal checks.
module tb_telemetry_rx;
  localparam int D = 16;
  localparam int H = D / 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RX  = 1'b1;
  logic [11:0] batt_v, avg_curr, avg_torque;
  logic        pkt_vld, frame_err, pkt_err;

  telemetry_rx #(.BAUD_DIV(D)) dut (
    .clk(clk), .rst(rst), .RX(RX),
    .batt_v(batt_v), .avg_curr(avg_curr), .avg_torque(avg_torque),
    .pkt_vld(pkt_vld), .frame_err(frame_err), .pkt_err(pkt_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  int n_vld = 0, n_ferr = 0, n_perr = 0, last_vld_cyc = 0, last_start = 0;

  typedef struct {int cyc; logic [7:0] d; logic ok;} ev_t;
  ev_t evq[$];

  // model state: hunting flag/count, payload, pending next-cycle results
  int          m_cnt = -1;
  bit          m_aa  = 1'b0;
  logic [7:0]  m_pay [6];
  logic [11:0] m_b = '0, m_c = '0, m_t = '0;
  logic        p_vld = 1'b0, p_err = 1'b0;
  logic [11:0] p_b, p_c, p_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_cnt < 0) begin
      if (m_aa && b == 8'h55) begin m_cnt = 0; m_aa = 1'b0; end
      else m_aa = (b == 8'hAA);
    end else begin
      m_pay[m_cnt] = b;
`ifdef TELEM_RX_CHECK_EN
      if (m_cnt % 2 == 0 && b[7:4] != 4'h0) begin
        p_err = 1'b1;
        m_cnt = -1;
        return;
      end
`endif
      m_cnt++;
      if (m_cnt == 6) begin
        p_vld = 1'b1;
        p_b = {m_pay[0][3:0], m_pay[1]};
        p_c = {m_pay[2][3:0], m_pay[3]};
        p_t = {m_pay[4][3:0], m_pay[5]};
        m_cnt = -1;
      end
    end
  endtask

  always @(negedge clk) begin
    logic e_vld, e_err, e_ferr;
    ev_t  ev;
    e_vld = 1'b0; e_err = 1'b0; e_ferr = 1'b0;
    if (rst) begin
      m_cnt = -1; m_aa = 1'b0; p_vld = 1'b0; p_err = 1'b0;
      m_b = '0; m_c = '0; m_t = '0;
      evq.delete();
    end else begin
      e_vld = p_vld;
      e_err = p_err;
      if (p_vld) begin m_b = p_b; m_c = p_c; m_t = p_t; end
      p_vld = 1'b0;
      p_err = 1'b0;
      while (evq.size() > 0 && evq[0].cyc <= cyc) begin
        ev = evq.pop_front();
        if (ev.cyc == cyc) begin
          if (!ev.ok) begin e_ferr = 1'b1; m_cnt = -1; m_aa = 1'b0; end
          else model_byte(ev.d);
        end
      end
    end
    chk("pkt_vld", 32'(pkt_vld), 32'(e_vld));
    chk("frame_err", 32'(frame_err), 32'(e_ferr));
    chk("pkt_err", 32'(pkt_err), 32'(e_err));
    chk("batt_v", 32'(batt_v), 32'(m_b));
    chk("avg_curr", 32'(avg_curr), 32'(m_c));
    chk("avg_torque", 32'(avg_torque), 32'(m_t));
    if (pkt_vld)   begin n_vld++; last_vld_cyc = cyc; end
    if (frame_err) n_ferr++;
    if (pkt_err)   n_perr++;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic ok);
    ev_t ev;
    last_start = cyc;
    RX = 1'b0;
    tick(D);
    for (int i = 0; i < 8; i++) begin RX = d[i]; tick(D); end
    RX = ok;
    ev.cyc = last_start + 3 + H + 9 * D;
    ev.d   = d;
    ev.ok  = ok;
    evq.push_back(ev);
    tick(D);
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send_byte(s[i], 1'b1);
  endtask

  task automatic chk_out(input string nm, input logic [11:0] b, input logic [11:0] c,
                         input logic [11:0] t);
    chk({nm, " batt_v"}, 32'(batt_v), 32'(b));
    chk({nm, " avg_curr"}, 32'(avg_curr), 32'(c));
    chk({nm, " avg_torque"}, 32'(avg_torque), 32'(t));
  endtask

  logic [7:0] seq[$];
  int v0, f0, e0;

  initial begin
    tick(3);
    chk_out("reset", 12'h000, 12'h000, 12'h000);
    chk("reset pkt_vld", 32'(pkt_vld), 32'h0);
    rst = 1'b0;
    tick(2 * D);

    // clean packet
    v0 = n_vld; f0 = n_ferr; e0 = n_perr;
    seq = '{8'hAA, 8'h55, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h00, 8'hFF};
    send_seq(seq);
    tick(D);
    chk("clean vld count", 32'(n_vld - v0), 32'd1);
    chk("clean err count", 32'(n_ferr - f0 + n_perr - e0), 32'd0);
    chk("clean latency", 32'(last_vld_cyc - last_start), 32'(4 + H + 9 * D));
    chk_out("clean", 12'hABC, 12'h123, 12'h0FF);

    // resync through a junk byte and a repeated AA
    v0 = n_vld;
    seq = '{8'h3C, 8'hAA, 8'hAA, 8'h55, 8'h08, 8'h00, 8'h08, 8'h00, 8'h08, 8'h00};
    send_seq(seq);
    tick(D);
    chk("resync vld count", 32'(n_vld - v0), 32'd1);
    chk_out("resync", 12'h800, 12'h800, 12'h800);

    // short glitch must be rejected as a false start
    v0 = n_vld;
    RX = 1'b0; tick(D / 4); RX = 1'b1; tick(2 * D);
    seq = '{8'hAA, 8'h55, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h00, 8'hFF};
    send_seq(seq);
    tick(D);
    chk("glitch vld count", 32'(n_vld - v0), 32'd1);
    chk_out("glitch", 12'hABC, 12'h123, 12'h0FF);

    // framing error on byte 4, then a clean packet
    v0 = n_vld; f0 = n_ferr;
    seq = '{8'hAA, 8'h55, 8'h0A};
    send_seq(seq);
    send_byte(8'hBC, 1'b0);
    RX = 1'b1; tick(3 * D);
    chk("ferr count", 32'(n_ferr - f0), 32'd1);
    chk("ferr vld count", 32'(n_vld - v0), 32'd0);
    chk_out("ferr hold", 12'hABC, 12'h123, 12'h0FF);
    seq = '{8'hAA, 8'h55, 8'h03, 8'h21, 8'h04, 8'h56, 8'h07, 8'h89};
    send_seq(seq);
    tick(D);
    chk("post-ferr vld count", 32'(n_vld - v0), 32'd1);
    chk_out("post-ferr", 12'h321, 12'h456, 12'h789);

    // nonzero upper nibble in payload byte 1
    v0 = n_vld; e0 = n_perr;
    seq = '{8'hAA, 8'h55, 8'h1A, 8'hBC, 8'h01, 8'h23, 8'h00, 8'hFF};
    send_seq(seq);
    tick(D);
`ifdef TELEM_RX_CHECK_EN
    chk("nibble perr count", 32'(n_perr - e0), 32'd1);
    chk("nibble vld count", 32'(n_vld - v0), 32'd0);
    chk_out("nibble", 12'h321, 12'h456, 12'h789);
`else
    chk("nibble perr count", 32'(n_perr - e0), 32'd0);
    chk("nibble vld count", 32'(n_vld - v0), 32'd1);
    chk_out("nibble", 12'hABC, 12'h123, 12'h0FF);
`endif

    // reset in the middle of byte 5, then finish the old packet
    seq = '{8'hAA, 8'h55, 8'h0A, 8'hBC};
    send_seq(seq);
    RX = 1'b0; tick(D); RX = 1'b1; tick(D); RX = 1'b0; tick(D / 2);
    rst = 1'b1; tick(3);
    RX = 1'b1;
    chk_out("mid reset", 12'h000, 12'h000, 12'h000);
    rst = 1'b0;
    tick(2 * D);
    v0 = n_vld;
    seq = '{8'h01, 8'h23, 8'h00, 8'hFF};
    send_seq(seq);
    tick(D);
    chk("post-reset vld count", 32'(n_vld - v0), 32'd0);
    chk_out("post-reset", 12'h000, 12'h000, 12'h000);
    seq = '{8'hAA, 8'h55, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h00, 8'hFF};
    send_seq(seq);
    tick(D);
    chk("fresh vld count", 32'(n_vld - v0), 32'd1);
    chk_out("fresh", 12'hABC, 12'h123, 12'h0FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
